move_sequencer: RTL
===================

MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 SHALL have parameter: EMPTY_CODE, default 4'd15, board code for an empty square.
REQ-002 SHALL have port: CLOCK_50  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req_valid in 1 and req_ready out 1, the move-request handshake; transfer on the edge where both are high.
REQ-005 SHALL have ports: old_x, old_y, new_x, new_y, each in 3, move coordinates sampled at transfer.
REQ-006 SHALL have ports: rd_x, rd_y out 3 (board read address) and rd_data in 4 (board[rd_y][rd_x], combinational, same cycle).
REQ-007 SHALL have ports: wr_en out 1, wr_x/wr_y out 3, wr_data out 4, a board write port committed on the edge where wr_en=1.
REQ-008 SHALL have ports: done out 1 (one-cycle result pulse), accepted out 1 (valid only while done=1), turn out 1 (0 white, 1 black).

Function
REQ-009 SHALL use piece codes 0-5 white R,N,B,Q,K,P; 6-11 black R,N,B,Q,K,P; EMPTY_CODE empty.
REQ-010 SHALL implement states IDLE, FETCH_SRC, FETCH_DST, SCAN, COMMIT_DST, COMMIT_SRC, RESULT; req_ready=1 only in IDLE; requests in other states are not accepted.
REQ-011 SHALL latch coordinates at transfer, compute dx=|new_x-old_x|, dy=|new_y-old_y| (3-bit unsigned, no wrap), and enter FETCH_SRC.
REQ-012 FETCH_SRC: read old square; reject if empty, if old==new, or if colour rule (REQ-024) fails; else FETCH_DST.
REQ-013 FETCH_DST: read new square; reject if occupied by own colour or if geometry fails: rook dx=0 xor dy=0; bishop dx=dy; queen either; knight {dx,dy}={1,2}; king max(dx,dy)=1.
REQ-014 Pawn: white forward is +y, black -y; one forward step requires empty destination; two forward steps only from y=1 (white) / y=6 (black) with empty destination; diagonal dx=1, dy=1 forward requires opposite-colour destination; else reject.
REQ-015 Intermediate count n = max(dx,dy)-1 for R, B, Q and the pawn double step; n=0 otherwise; n=0 skips SCAN.
REQ-016 SCAN SHALL read exactly one intermediate square per cycle, walking from old toward new; the first non-empty square rejects immediately.
REQ-017 On pass: COMMIT_DST writes source piece to (new_x,new_y); COMMIT_SRC writes EMPTY_CODE to (old_x,old_y); then RESULT.
REQ-018 Reject from any state SHALL go directly to RESULT with no write.
REQ-019 RESULT: done=1 for one cycle, accepted=pass/fail; next state IDLE.
REQ-020 Latency from transfer edge: accepted RESULT in cycle 5+n; reject in FETCH_SRC -> cycle 2; in FETCH_DST -> cycle 3; at scan square k (1-based) -> cycle 3+k.
REQ-021 wr_en SHALL be high only in COMMIT_DST and COMMIT_SRC; done only in RESULT.

Reset
REQ-022 Reset SHALL force IDLE, req_ready=1, done=0, accepted=0, wr_en=0, turn=0, rd/wr addresses and wr_data 0; takes priority over all events.
REQ-023 Reset mid-operation SHALL abandon the move without further writes; a reset between COMMIT_DST and COMMIT_SRC leaves the board for the board-initialisation path to restore.

Configuration
REQ-024 Macro TURN_ENFORCE_EN defined: source colour must equal turn, else reject; turn toggles on the RESULT cycle when accepted=1. Undefined: any colour may move; turn held at 0.

Verification
REQ-025 Reset; white pawn (1,1)->(1,3), (1,2),(1,3) empty -> writes (1,3)=5 then (1,1)=15, done/accepted=1 in cycle 6, turn=1.
REQ-026 White rook (0,0)->(0,7), board(0,3)=6 -> done, accepted=0 in cycle 6, wr_en never high, turn unchanged.
REQ-027 TURN_ENFORCE_EN, turn=0, black pawn (4,6)->(4,5) -> reject, done in cycle 2, no write.
REQ-028 White knight (1,0)->(2,2), (1,1),(2,1) occupied, (2,2)=11 -> accepted, done in cycle 5, (2,2)=1, (1,0)=15.
REQ-029 Reset asserted during SCAN of queen (3,0)->(3,5) -> next cycle IDLE, req_ready=1, no wr_en, turn=0; old==new request (2,2)->(2,2) -> reject in cycle 2.

Source files
------------

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - chess move validator/committer over an 8x8 board port; optional TURN_ENFORCE_EN
module move_sequencer #(
  parameter logic [3:0] EMPTY_CODE = 4'd15
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] old_x,
  input  logic [2:0] old_y,
  input  logic [2:0] new_x,
  input  logic [2:0] new_y,
  output logic [2:0] rd_x,
  output logic [2:0] rd_y,
  input  logic [3:0] rd_data,
  output logic       wr_en,
  output logic [2:0] wr_x,
  output logic [2:0] wr_y,
  output logic [3:0] wr_data,
  output logic       done,
  output logic       accepted,
  output logic       turn
);

  typedef enum logic [2:0] {
    IDLE, FETCH_SRC, FETCH_DST, SCAN, COMMIT_DST, COMMIT_SRC, RESULT
  } state_t;

  state_t state, next_state;

  logic [2:0] ox, oy, nx, ny;
  logic [2:0] dx, dy;
  logic [3:0] piece;
  logic [2:0] cx, cy;
  logic [2:0] remain;
  logic       pass;
  logic       turn_q;

  logic       latch_piece, load_scan, scan_advance;

  // Derived move properties, all from latched coordinates and piece.
  logic       p_black;
  logic [3:0] kind;
  logic [2:0] mx;
  logic [2:0] step_x, step_y;
  logic       straight, diag, knight_ok, king_ok;
  logic       forward, pawn_ok, pawn_double;
  logic       dst_empty, dst_own;
  logic       geom_ok;
  logic [2:0] scan_n;
  logic       src_reject;
  logic       colour_ok;

  always_comb begin
    p_black     = (piece >= 4'd6);
    kind        = p_black ? (piece - 4'd6) : piece;
    mx          = (dx > dy) ? dx : dy;
    step_x      = (nx > ox) ? 3'd1 : ((nx < ox) ? 3'd7 : 3'd0);
    step_y      = (ny > oy) ? 3'd1 : ((ny < oy) ? 3'd7 : 3'd0);
    straight    = (dx == 3'd0) ^ (dy == 3'd0);
    diag        = (dx == dy);
    knight_ok   = ((dx == 3'd1) && (dy == 3'd2)) || ((dx == 3'd2) && (dy == 3'd1));
    king_ok     = (mx == 3'd1);
    forward     = p_black ? (ny < oy) : (ny > oy);
    dst_empty   = (rd_data == EMPTY_CODE);
    dst_own     = !dst_empty && ((rd_data >= 4'd6) == p_black);
    pawn_double = (dx == 3'd0) && (dy == 3'd2) && forward && dst_empty &&
                  (oy == (p_black ? 3'd6 : 3'd1));
    pawn_ok     = ((dx == 3'd0) && (dy == 3'd1) && forward && dst_empty) ||
                  pawn_double ||
                  ((dx == 3'd1) && (dy == 3'd1) && forward && !dst_empty);
    case (kind)
      4'd0:    geom_ok = straight;
      4'd1:    geom_ok = knight_ok;
      4'd2:    geom_ok = diag;
      4'd3:    geom_ok = straight || diag;
      4'd4:    geom_ok = king_ok;
      4'd5:    geom_ok = pawn_ok;
      default: geom_ok = 1'b0;
    endcase
    if ((kind == 4'd0) || (kind == 4'd2) || (kind == 4'd3) || ((kind == 4'd5) && pawn_double))
      scan_n = mx - 3'd1;
    else
      scan_n = 3'd0;
`ifdef TURN_ENFORCE_EN
    colour_ok = ((rd_data >= 4'd6) == turn_q);
`else
    colour_ok = 1'b1;
`endif
    src_reject = (rd_data == EMPTY_CODE) || (rd_data > 4'd11) ||
                 ((ox == nx) && (oy == ny)) || !colour_ok;
  end

  always_comb begin
    next_state   = state;
    latch_piece  = 1'b0;
    load_scan    = 1'b0;
    scan_advance = 1'b0;
    case (state)
      IDLE: if (req_valid) next_state = FETCH_SRC;
      FETCH_SRC: begin
        if (src_reject) begin
          next_state = RESULT;
        end else begin
          next_state  = FETCH_DST;
          latch_piece = 1'b1;
        end
      end
      FETCH_DST: begin
        if (dst_own || !geom_ok) begin
          next_state = RESULT;
        end else if (scan_n == 3'd0) begin
          next_state = COMMIT_DST;
        end else begin
          next_state = SCAN;
          load_scan  = 1'b1;
        end
      end
      SCAN: begin
        // First blocker on the path ends the move; no board write happens.
        if (rd_data != EMPTY_CODE)
          next_state = RESULT;
        else if (remain == 3'd1)
          next_state = COMMIT_DST;
        else
          scan_advance = 1'b1;
      end
      COMMIT_DST: next_state = COMMIT_SRC;
      COMMIT_SRC: next_state = RESULT;
      RESULT:     next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state  <= IDLE;
      ox     <= 3'd0;
      oy     <= 3'd0;
      nx     <= 3'd0;
      ny     <= 3'd0;
      dx     <= 3'd0;
      dy     <= 3'd0;
      piece  <= 4'd0;
      cx     <= 3'd0;
      cy     <= 3'd0;
      remain <= 3'd0;
      pass   <= 1'b0;
      turn_q <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == IDLE) && req_valid) begin
        ox   <= old_x;
        oy   <= old_y;
        nx   <= new_x;
        ny   <= new_y;
        dx   <= (new_x >= old_x) ? (new_x - old_x) : (old_x - new_x);
        dy   <= (new_y >= old_y) ? (new_y - old_y) : (old_y - new_y);
        pass <= 1'b0;
      end
      if (latch_piece)
        piece <= rd_data;
      if (load_scan) begin
        cx     <= ox + step_x;
        cy     <= oy + step_y;
        remain <= scan_n;
      end
      if (scan_advance) begin
        cx     <= cx + step_x;
        cy     <= cy + step_y;
        remain <= remain - 3'd1;
      end
      if (state == COMMIT_SRC)
        pass <= 1'b1;
`ifdef TURN_ENFORCE_EN
      if ((state == RESULT) && pass)
        turn_q <= ~turn_q;
`endif
    end
  end

  // Outputs are held quiet while reset is high so an interrupted commit cannot land.
  always_comb begin
    req_ready = (state == IDLE);
    rd_x      = 3'd0;
    rd_y      = 3'd0;
    wr_en     = 1'b0;
    wr_x      = 3'd0;
    wr_y      = 3'd0;
    wr_data   = 4'd0;
    done      = 1'b0;
    accepted  = 1'b0;
    turn      = turn_q;
    if (!reset) begin
      case (state)
        FETCH_SRC: begin
          rd_x = ox;
          rd_y = oy;
        end
        FETCH_DST: begin
          rd_x = nx;
          rd_y = ny;
        end
        SCAN: begin
          rd_x = cx;
          rd_y = cy;
        end
        COMMIT_DST: begin
          wr_en   = 1'b1;
          wr_x    = nx;
          wr_y    = ny;
          wr_data = piece;
        end
        COMMIT_SRC: begin
          wr_en   = 1'b1;
          wr_x    = ox;
          wr_y    = oy;
          wr_data = EMPTY_CODE;
        end
        RESULT: begin
          done     = 1'b1;
          accepted = pass;
        end
        default: ;
      endcase
    end
  end

endmodule
